// File: rtl/blink_led_pkg.sv
// Shared constants and width helper for the LED blinker.
package blink_led_pkg;

   localparam int unsigned CLK_HZ              = 100_000_000;
   localparam int unsigned DEFAULT_HALF_PERIOD = CLK_HZ / 2;
   localparam int unsigned DEFAULT_PWM_PERIOD  = 16;
   localparam int unsigned DEFAULT_PWM_DUTY    = 4;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/blink_led_tick.sv
// Terminal-count prescaler: counts 0..CYCLES-1, ticks on the last count.
module blink_led_tick
   import blink_led_pkg::*;
#(
   parameter  int unsigned CYCLES = 2,
   localparam int unsigned W      = cnt_width(CYCLES)
) (
   input  logic         clk,
   input  logic         rst,
   output logic         tick,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] LAST = W'(CYCLES - 1);

   logic [W-1:0] cnt_q = '0;
   logic [W-1:0] cnt_d;

   always_comb begin
      tick  = (cnt_q == LAST);
      cnt_d = tick ? '0 : cnt_q + W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/blink_led.sv
// Free-running LED blinker; define BLINK_LED_PWM_EN to dim the on phase.
module blink_led
   import blink_led_pkg::*;
#(
   parameter int unsigned HALF_PERIOD_CYCLES = DEFAULT_HALF_PERIOD,
   parameter int unsigned PWM_PERIOD         = DEFAULT_PWM_PERIOD,
   parameter int unsigned PWM_DUTY           = DEFAULT_PWM_DUTY
) (
   input  logic clk,
   input  logic rst,
   output logic led
);

   localparam int unsigned HW = cnt_width(HALF_PERIOD_CYCLES);
   localparam int unsigned PW = cnt_width(PWM_PERIOD);

   if (HALF_PERIOD_CYCLES == 0) begin : g_bad_half
      $error("blink_led: HALF_PERIOD_CYCLES must be >= 1");
   end
   if (PWM_PERIOD < 2 || PWM_DUTY > PWM_PERIOD) begin : g_bad_pwm
      $error("blink_led: need PWM_PERIOD >= 2 and PWM_DUTY <= PWM_PERIOD");
   end

   logic          half_tick;
   logic [HW-1:0] unused_half_cnt;

   blink_led_tick #(
      .CYCLES (HALF_PERIOD_CYCLES)
   ) u_half (
      .clk  (clk),
      .rst  (rst),
      .tick (half_tick),
      .cnt  (unused_half_cnt)
   );

   logic phase_q = 1'b0;
   logic phase_d;

   always_comb begin
      phase_d = half_tick ? ~phase_q : phase_q;
   end

   always_ff @(posedge clk) begin
      if (rst) phase_q <= 1'b0;
      else     phase_q <= phase_d;
   end

`ifdef BLINK_LED_PWM_EN
   logic          unused_pwm_tick;
   logic [PW-1:0] pwm_cnt;

   blink_led_tick #(
      .CYCLES (PWM_PERIOD)
   ) u_pwm (
      .clk  (clk),
      .rst  (rst),
      .tick (unused_pwm_tick),
      .cnt  (pwm_cnt)
   );

   logic pwm_on_q = 1'b0;
   logic pwm_on_d;

   always_comb begin
      pwm_on_d = (32'(pwm_cnt) < PWM_DUTY);
   end

   always_ff @(posedge clk) begin
      if (rst) pwm_on_q <= 1'b0;
      else     pwm_on_q <= pwm_on_d;
   end

   assign led = phase_q & pwm_on_q;
`else
   assign led = phase_q;
`endif

endmodule

// File: tb/tb_blink_led.sv
// Scoreboard bench: half-period 4 with reset pulses, half-period 1, never-reset.
module tb_blink_led;

   localparam int unsigned NCYC = 48;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_tie = 1'b0;
   logic led_a;
   logic led_b;
   logic led_c;

   int n_checks = 0;
   int n_errors = 0;

   bit q_a[$];
   bit q_b[$];
   bit q_c[$];

   always #5 clk = ~clk;

   blink_led #(.HALF_PERIOD_CYCLES(4)) u_a (
      .clk (clk),
      .rst (rst),
      .led (led_a)
   );

   blink_led #(.HALF_PERIOD_CYCLES(1)) u_b (
      .clk (clk),
      .rst (rst),
      .led (led_b)
   );

   blink_led #(.HALF_PERIOD_CYCLES(4)) u_c (
      .clk (clk),
      .rst (rst_tie),
      .led (led_c)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
      end
   endtask

   // led after e non-reset edges since the last reset (or power-up)
   function automatic bit model(input int e, input int h);
      return bit'((e / h) % 2);
   endfunction

   int e_a = 0;
   int e_b = 0;
   int e_c = 0;

   initial begin
      #1;
      chk("init_a", led_a, 1'b0);
      chk("init_b", led_b, 1'b0);
      chk("init_c", led_c, 1'b0);
      for (int cyc = 0; cyc < NCYC; cyc++) begin
         rst = (cyc < 2) || (cyc == 7) || (cyc == 30);
         if (rst) begin
            e_a = 0;
            e_b = 0;
         end else begin
            e_a++;
            e_b++;
         end
         e_c++;
         q_a.push_back(model(e_a, 4));
         q_b.push_back(model(e_b, 1));
         q_c.push_back(model(e_c, 4));
         @(posedge clk);
         #1;
         if (q_a.size() == 0 || q_b.size() == 0 || q_c.size() == 0) begin
            chk("queue_empty", 1'b1, 1'b0);
         end else begin
            chk($sformatf("a_cyc%0d", cyc), led_a, q_a.pop_front());
            chk($sformatf("b_cyc%0d", cyc), led_b, q_b.pop_front());
            chk($sformatf("c_cyc%0d", cyc), led_c, q_c.pop_front());
         end
      end
      chk("queue_drained", 1'(q_a.size() + q_b.size() + q_c.size()), 1'b0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
